// File: rtl/jtcontra_gfx_romarb.sv
// Graphics ROM port arbiter for one 007121 instance: shares the 16-bit SDRAM
// read port between the tilemap (scr) and object (obj) fetchers.
module jtcontra_gfx_romarb #(
  parameter int AW = 18,
  parameter int RR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    gfx_en,
  input  logic          scr_cs,
  input  logic [AW-1:0] scr_addr,
  output logic          scr_ok,
  output logic [15:0]   scr_data,
  input  logic          obj_cs,
  input  logic [AW-1:0] obj_addr,
  output logic          obj_ok,
  output logic [15:0]   obj_data,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  output logic          rom_obj_sel,
  input  logic          rom_ok,
  input  logic [15:0]   rom_data,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DATA = 2'd2} state_t;

  state_t        st;
  logic          scr_cs_l, obj_cs_l, ptr_obj, gnt_obj;
  logic [AW-1:0] scr_addr_l, obj_addr_l, gnt_addr;
  logic          new_scr, new_obj, pend_scr, pend_obj, req_scr, req_obj, pick_obj;

  assign busy = (st != IDLE);

  // A requester already in flight is not pending, so it is neither re-granted
  // nor answered by the gating path while its SDRAM access is open.
  always_comb begin
    new_scr  = scr_cs & (~scr_cs_l | (scr_addr != scr_addr_l));
    new_obj  = obj_cs & (~obj_cs_l | (obj_addr != obj_addr_l));
    pend_scr = scr_cs & ~scr_ok & ~(busy & ~gnt_obj);
    pend_obj = obj_cs & ~obj_ok & ~(busy & gnt_obj);
    req_scr  = pend_scr & gfx_en[0];
    req_obj  = pend_obj & gfx_en[1];
    pick_obj = req_obj & (~req_scr | ((RR != 0) & ptr_obj));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      rom_cs      <= 1'b0;
      rom_addr    <= '0;
      rom_obj_sel <= 1'b0;
      scr_ok      <= 1'b0;
      obj_ok      <= 1'b0;
      scr_data    <= '0;
      obj_data    <= '0;
      scr_cs_l    <= 1'b0;
      obj_cs_l    <= 1'b0;
      scr_addr_l  <= '0;
      obj_addr_l  <= '0;
      gnt_addr    <= '0;
      gnt_obj     <= 1'b0;
      ptr_obj     <= 1'b0;
    end else begin
      scr_cs_l   <= scr_cs;
      obj_cs_l   <= obj_cs;
      scr_addr_l <= scr_addr;
      obj_addr_l <= obj_addr;

      if (!scr_cs || new_scr) scr_ok <= 1'b0;
      if (!obj_cs || new_obj) obj_ok <= 1'b0;
      // Disabled layers are answered with blank data without touching SDRAM
      if (pend_scr && !gfx_en[0]) begin
        scr_ok   <= 1'b1;
        scr_data <= '0;
      end
      if (pend_obj && !gfx_en[1]) begin
        obj_ok   <= 1'b1;
        obj_data <= '0;
      end

      case (st)
        IDLE: begin
          if (req_scr || req_obj) begin
            rom_cs      <= 1'b1;
            rom_addr    <= pick_obj ? obj_addr : scr_addr;
            gnt_addr    <= pick_obj ? obj_addr : scr_addr;
            rom_obj_sel <= pick_obj;
            gnt_obj     <= pick_obj;
            if (RR != 0) ptr_obj <= ~ptr_obj;
            st          <= WAIT;
          end else begin
            rom_cs <= 1'b0;
          end
        end
        // rom_ok seen here still belongs to the previous access
        WAIT: st <= DATA;
        DATA: begin
          if (rom_ok) begin
            rom_cs <= 1'b0;
            st     <= IDLE;
            // Data is only delivered if the requester still wants this address
            if (gnt_obj) begin
              if (obj_cs && (obj_addr == gnt_addr)) begin
                obj_data <= rom_data;
                obj_ok   <= 1'b1;
              end
            end else if (scr_cs && (scr_addr == gnt_addr)) begin
              scr_data <= rom_data;
              scr_ok   <= 1'b1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
